// File: rtl/cordic_sincos_if.sv
// Handshake bundle for the CORDIC sin/cos block.
// The angle producer and result consumer connect through master; the block itself connects through slave.
interface cordic_sincos_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] cos_out;
  logic [31:0] sin_out;

  modport master (
    output in_valid, angle, out_ready,
    input  in_ready, out_valid, cos_out, sin_out
  );

  modport slave (
    input  in_valid, angle, out_ready,
    output in_ready, out_valid, cos_out, sin_out
  );
endinterface

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: signed Q8.24 degree angle in, signed Q2.30 cos/sin out.
// One micro-rotation per clock, one transaction in flight, valid/ready on both sides.
module cordic_sincos #(
  parameter int          ITER  = 32,
  parameter logic [31:0] KGAIN = 32'h26DD3B6A
) (
  input logic            clk,
  input logic            rst,
  cordic_sincos_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, DONE = 2'd2} state_e;

  localparam logic [5:0]         LAST_CNT = 6'(ITER - 1);
  localparam logic [39:0]        K_FIX    = {KGAIN, 8'h00};
  localparam logic [39:0]        DEG90    = 40'h5A_0000_0000;
  localparam logic signed [31:0] POS90    = 32'sh5A00_0000;
  localparam logic signed [31:0] NEG90    = 32'shA600_0000;
  localparam logic [255:0]       ONE_Q    = 256'd1 << 120;

  // atan(1/n) in radians, Q.120, from the alternating Taylor series.
  function automatic logic [255:0] atan_recip(input logic [255:0] n);
    logic [255:0] pw;
    logic [255:0] sum;
    logic [255:0] nsq;
    nsq = n * n;
    pw  = ONE_Q / n;
    sum = 256'd0;
    for (int k = 0; k < 64; k++) begin
      if (k[0]) begin
        sum = sum - (pw / 256'(2 * k + 1));
      end else begin
        sum = sum + (pw / 256'(2 * k + 1));
      end
      pw = pw / nsq;
    end
    return sum;
  endfunction

  // atan(2^-idx) in degrees, Q8.32, rounded; pi/4 comes from Machin's formula.
  function automatic logic [39:0] atan_deg(input int idx);
    logic [255:0] quarter_pi;
    logic [255:0] deg;
    if (idx == 0) begin
      deg = 256'h2D_0000_0000;
    end else begin
      quarter_pi = (256'd4 * atan_recip(256'd5)) - atan_recip(256'd239);
      deg = ((256'd45 << 32) * atan_recip(256'd1 << idx) + (quarter_pi >> 1)) / quarter_pi;
    end
    return 40'(deg);
  endfunction

  logic [39:0] atan_tab_s [64];

  for (genvar g = 0; g < 64; g++) begin : g_atan
    localparam logic [39:0] ATAN_G = (g < 38) ? atan_deg(g) : 40'd0;
    assign atan_tab_s[g] = ATAN_G;
  end

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic signed [39:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [31:0]        cos_q, cos_d, sin_q, sin_d;
  logic signed [39:0] x_rot_s, y_rot_s, z_rot_s, z_in_s;

  // One micro-rotation of the held vector by +/-atan(2^-cnt); z=0 rotates positively.
  always_comb begin
    x_rot_s = x_q;
    y_rot_s = y_q;
    z_rot_s = z_q;
    if (z_q[39] == 1'b0) begin
      x_rot_s = x_q - (y_q >>> cnt_q);
      y_rot_s = y_q + (x_q >>> cnt_q);
      z_rot_s = z_q - $signed(atan_tab_s[cnt_q]);
    end else begin
      x_rot_s = x_q + (y_q >>> cnt_q);
      y_rot_s = y_q - (x_q >>> cnt_q);
      z_rot_s = z_q + $signed(atan_tab_s[cnt_q]);
    end
  end

  // Next-state and datapath load; beyond +/-90 the vector starts on the y axis.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    z_in_s  = {bus.angle, 8'h00};
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = ROTATE;
          cnt_d   = 6'd0;
          if ($signed(bus.angle) > POS90) begin
            x_d = 40'sd0;
            y_d = K_FIX;
            z_d = z_in_s - DEG90;
          end else if ($signed(bus.angle) < NEG90) begin
            x_d = 40'sd0;
            y_d = -K_FIX;
            z_d = z_in_s + DEG90;
          end else begin
            x_d = K_FIX;
            y_d = 40'sd0;
            z_d = z_in_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ROTATE: begin
        x_d   = x_rot_s;
        y_d   = y_rot_s;
        z_d   = z_rot_s;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = 6'd0;
          cos_d   = x_rot_s[39:8];
          sin_d   = y_rot_s[39:8];
        end else begin
          state_d = ROTATE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction or held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      x_q     <= 40'sd0;
      y_q     <= 40'sd0;
      z_q     <= 40'sd0;
      cos_q   <= 32'd0;
      sin_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: directed and random angles checked against real-valued
// sin/cos, plus reset, latency, spacing, backpressure and mid-transaction reset behaviour.
`timescale 1ns/1ps
module tb_cordic_sincos;
  localparam int  ITER = 32;
  localparam real PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  cordic_sincos_if bus();

  cordic_sincos #(.ITER(ITER), .KGAIN(32'h26DD3B6A)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input real ref_v);
    real  diff;
    logic ok;
    diff = $itor($signed(obs)) - ref_v;
    ok = (diff <= 16.0) && (diff >= -16.0);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/-16", tag, $signed(obs), $rtoi(ref_v));
    end
  endtask

  // Reference: exact trigonometry of the angle, scaled to Q2.30.
  task automatic check_result(input logic [31:0] a, input string tag);
    real rad;
    rad = ($itor($signed(a)) / 16777216.0) * PI / 180.0;
    check_near({tag, " cos"}, bus.cos_out, $cos(rad) * 1073741824.0);
    check_near({tag, " sin"}, bus.sin_out, $sin(rad) * 1073741824.0);
  endtask

  // Present one angle, wait for the result, check latency and value; release if out_ready is high.
  task automatic txn(input logic [31:0] a, input string tag);
    int n;
    bus.angle    = a;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check({tag, " accept"}, 32'(n < 64), 32'd1);
    acc_cyc = cyc;
    tick();
    bus.in_valid = 1'b0;
    bus.angle    = $urandom();
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(ITER));
    check_result(a, tag);
    if (bus.out_ready) begin
      tick();
      check({tag, " release"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    end
  endtask

  initial begin
    int          first_acc;
    logic [31:0] c_hold;
    logic [31:0] s_hold;
    logic        seen;
    logic [31:0] ra;

    // Reset with in_valid asserted
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.angle     = 32'h1E00_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("post-rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post-rst cos", bus.cos_out, 32'd0);
    check("post-rst sin", bus.sin_out, 32'd0);

    // Zero angle then 30 degrees back to back: accept spacing is ITER+2
    txn(32'h0000_0000, "zero");
    first_acc = acc_cyc;
    txn(32'h1E00_0000, "30deg");
    check("spacing", 32'(acc_cyc - first_acc), 32'(ITER + 2));

    txn(32'hD300_0000, "-45deg");
    txn(32'h7800_0000, "120deg");
    txn(32'h8800_0000, "-120deg");
    txn(32'h5A00_0000, "90deg");
    txn(32'hA600_0000, "-90deg");
    txn(32'h5A00_0001, "90+lsb");
    txn(32'hA5FF_FFFF, "-90-lsb");
    txn(32'h8000_0000, "-128deg");
    txn(32'h7FFF_FFFF, "max");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom();
      txn(ra, "random");
    end

    // Backpressure: result held in DONE while inputs wiggle
    bus.out_ready = 1'b0;
    txn(32'h3C00_0000, "bp");
    c_hold = bus.cos_out;
    s_hold = bus.sin_out;
    for (int i = 0; i < 10; i++) begin
      bus.angle    = $urandom();
      bus.in_valid = i[0];
      tick();
      check("bp cos", bus.cos_out, c_hold);
      check("bp sin", bus.sin_out, s_hold);
      check("bp flags", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    txn(32'h1E00_0000, "after-bp");

    // One-cycle reset at iteration 10 aborts the transaction
    bus.angle    = 32'h3C00_0000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort no out_valid", {31'd0, seen}, 32'd0);
    check("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    txn(32'h1E00_0000, "post-abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
